// File: rtl/reorder_buffer_pkg.sv
// Shared ROB widths and entry record, used by the ROB, reservation stations and the adder unit.
package reorder_buffer_pkg;
  localparam int ROB_DATA_W = 16;
  localparam int ROB_DEPTH  = 4;
  localparam int ROB_TAG_W  = 2;
  localparam int ROB_REG_W  = 3;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [ROB_REG_W-1:0]  dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_entry.sv
// Single ROB slot: alloc/clear/write update on the next edge; no backpressure.
// Controls are mutually exclusive by construction in the parent; reset wins.
module rob_entry
  import reorder_buffer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alloc,
  input  logic [ROB_REG_W-1:0]  alloc_dest,
  input  logic                  write,
  input  logic [ROB_DATA_W-1:0] write_data,
  input  logic                  clear,
  output rob_entry_t            entry
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      entry <= '0;
    end else if (alloc) begin
      entry.busy  <= 1'b1;
      entry.ready <= 1'b0;
      entry.dest  <= alloc_dest;
      entry.data  <= '0;
    end else if (clear) begin
      entry <= '0;
    end else if (write) begin
      entry.ready <= 1'b1;
      entry.data  <= write_data;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer; commit outputs registered one edge after the head turns ready.
// Issue is backpressured by alloc_ready (low when full); CDB and commit are never stalled.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DATA_W = ROB_DATA_W,
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  rd_tag1,
  input  logic [TAG_W-1:0]  rd_tag2,
  output logic              rd_ready1,
  output logic              rd_ready2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  rob_entry_t       ents [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             alloc_fire;
  logic             commit_fire;

  assign alloc_ready = (count != FULL);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = ents[head].busy && ents[head].ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    // Alloc only targets free slots and clear only the ready head, so the strobes never collide.
    rob_entry u_ent (
      .clock      (clock),
      .reset      (reset),
      .alloc      (alloc_fire && (tail == TAG_W'(i))),
      .alloc_dest (alloc_dest),
      .write      (cdb_valid && (cdb_tag == TAG_W'(i)) && ents[i].busy && !ents[i].ready),
      .write_data (cdb_data),
      .clear      (commit_fire && (head == TAG_W'(i))),
      .entry      (ents[i])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_data  <= '0;
    end else begin
      commit_valid <= commit_fire;
      if (commit_fire) begin
        commit_dest <= ents[head].dest;
        commit_data <= ents[head].data;
        head        <= head + 1'b1;
      end
      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Operand lookup; a same-cycle CDB broadcast to a busy entry bypasses the stored state.
  always_comb begin
    rd_ready1 = 1'b0;
    rd_data1  = '0;
    if (cdb_valid && (cdb_tag == rd_tag1) && ents[rd_tag1].busy) begin
      rd_ready1 = 1'b1;
      rd_data1  = cdb_data;
    end else if (ents[rd_tag1].busy && ents[rd_tag1].ready) begin
      rd_ready1 = 1'b1;
      rd_data1  = ents[rd_tag1].data;
    end
  end

  always_comb begin
    rd_ready2 = 1'b0;
    rd_data2  = '0;
    if (cdb_valid && (cdb_tag == rd_tag2) && ents[rd_tag2].busy) begin
      rd_ready2 = 1'b1;
      rd_data2  = cdb_data;
    end else if (ents[rd_tag2].busy && ents[rd_tag2].ready) begin
      rd_ready2 = 1'b1;
      rd_data2  = ents[rd_tag2].data;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [2:0]  alloc_dest = '0;
  logic        alloc_ready;
  logic [1:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [1:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic [1:0]  rd_tag1 = '0;
  logic [1:0]  rd_tag2 = '0;
  logic        rd_ready1, rd_ready2;
  logic [15:0] rd_data1, rd_data2;
  logic        commit_valid;
  logic [2:0]  commit_dest;
  logic [15:0] commit_data;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .rd_tag1      (rd_tag1),
    .rd_tag2      (rd_tag2),
    .rd_ready1    (rd_ready1),
    .rd_ready2    (rd_ready2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .commit_valid (commit_valid),
    .commit_dest  (commit_dest),
    .commit_data  (commit_data),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before driving/sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic alloc(input logic [2:0] d);
    alloc_valid = 1'b1;
    alloc_dest  = d;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [1:0] t, input logic [15:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_tag", 32'(alloc_tag), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);

    // Single alloc / CDB / commit
    alloc(3'd3);
    chk("t1_count_after_alloc", 32'(count), 1);
    cdb(2'd0, 16'h00AA);
    chk("t1_no_commit_at_cdb_edge", 32'(commit_valid), 0);
    step();
    chk("t1_commit_valid", 32'(commit_valid), 1);
    chk("t1_commit_dest", 32'(commit_dest), 3);
    chk("t1_commit_data", 32'(commit_data), 32'h00AA);
    chk("t1_count_zero", 32'(count), 0);
    step();
    chk("t1_single_pulse", 32'(commit_valid), 0);

    // Out-of-order completion, in-order commit
    do_reset();
    alloc(3'd1);
    alloc(3'd2);
    cdb(2'd1, 16'h1111);
    chk("t2_young_waits", 32'(commit_valid), 0);
    cdb(2'd0, 16'h2222);
    chk("t2_no_commit_yet", 32'(commit_valid), 0);
    step();
    chk("t2_c0_valid", 32'(commit_valid), 1);
    chk("t2_c0_dest", 32'(commit_dest), 1);
    chk("t2_c0_data", 32'(commit_data), 32'h2222);
    step();
    chk("t2_c1_valid", 32'(commit_valid), 1);
    chk("t2_c1_dest", 32'(commit_dest), 2);
    chk("t2_c1_data", 32'(commit_data), 32'h1111);
    step();
    chk("t2_done_valid", 32'(commit_valid), 0);
    chk("t2_done_count", 32'(count), 0);

    // Full buffer, ignored alloc, wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t3_alloc_tag", 32'(alloc_tag), 32'(i));
      alloc(3'(4 + i));
    end
    chk("t3_full_ready", 32'(alloc_ready), 0);
    chk("t3_full_count", 32'(count), 4);
    alloc(3'd0);
    chk("t3_ignored_count", 32'(count), 4);
    cdb(2'd0, 16'h5555);
    alloc_valid = 1'b1;
    alloc_dest  = 3'd0;
    step();
    chk("t3_commit_valid", 32'(commit_valid), 1);
    chk("t3_commit_dest", 32'(commit_dest), 4);
    chk("t3_commit_data", 32'(commit_data), 32'h5555);
    chk("t3_count_after_commit", 32'(count), 3);
    chk("t3_wrap_ready", 32'(alloc_ready), 1);
    chk("t3_wrap_tag", 32'(alloc_tag), 0);
    step();
    alloc_valid = 1'b0;
    chk("t3_realloc_count", 32'(count), 4);
    chk("t3_realloc_full", 32'(alloc_ready), 0);

    // Operand lookup and bypass
    do_reset();
    alloc(3'd1);
    alloc(3'd2);
    alloc(3'd3);
    rd_tag1   = 2'd2;
    rd_tag2   = 2'd1;
    cdb_valid = 1'b1;
    cdb_tag   = 2'd2;
    cdb_data  = 16'h0F0F;
    #1;
    chk("t4_bypass_ready", 32'(rd_ready1), 1);
    chk("t4_bypass_data", 32'(rd_data1), 32'h0F0F);
    chk("t4_other_ready", 32'(rd_ready2), 0);
    chk("t4_other_data", 32'(rd_data2), 0);
    step();
    cdb_valid = 1'b0;
    #1;
    chk("t4_stored_ready", 32'(rd_ready1), 1);
    chk("t4_stored_data", 32'(rd_data1), 32'h0F0F);
    rd_tag2   = 2'd3;
    cdb_valid = 1'b1;
    cdb_tag   = 2'd3;
    cdb_data  = 16'hBEEF;
    #1;
    chk("t4_free_no_bypass", 32'(rd_ready2), 0);
    chk("t4_free_no_data", 32'(rd_data2), 0);
    step();
    cdb_valid = 1'b0;
    #1;
    chk("t4_free_still_empty", 32'(rd_ready2), 0);
    chk("t4_free_count", 32'(count), 3);
    chk("t4_no_commit", 32'(commit_valid), 0);

    // Reset with in-flight entries (head made ready on the reset edge)
    cdb_valid = 1'b1;
    cdb_tag   = 2'd0;
    cdb_data  = 16'h1234;
    alloc_valid = 1'b1;
    do_reset();
    cdb_valid   = 1'b0;
    alloc_valid = 1'b0;
    #1;
    chk("t5_count", 32'(count), 0);
    chk("t5_alloc_tag", 32'(alloc_tag), 0);
    chk("t5_alloc_ready", 32'(alloc_ready), 1);
    chk("t5_rd_ready", 32'(rd_ready1), 0);
    chk("t5_rd_data", 32'(rd_data1), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_commit", 32'(commit_valid), 0);
      step();
    end
    chk("t5_no_commit_end", 32'(commit_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 16, CDB/result width; DEPTH, 4, entry count; TAG_W, 2, entry tag width (log2 DEPTH); REG_W, 3, architectural register index width.
REQ-002 Ports (name, direction, width, meaning): clock, in, 1, sole clock, all state updates on rising edge.
REQ-003 reset, in, 1, synchronous active-low reset.
REQ-004 alloc_valid, in, 1, issue requests an entry this cycle.
REQ-005 alloc_dest, in, REG_W, destination register of the issuing instruction.
REQ-006 alloc_ready, out, 1, entry available; high when count < DEPTH.
REQ-007 alloc_tag, out, TAG_W, tag granted on a successful allocation; equals the tail index.
REQ-008 cdb_valid, in, 1, CDB broadcast valid.
REQ-009 cdb_tag, in, TAG_W, producing entry tag on CDB.
REQ-010 cdb_data, in, DATA_W, result value on CDB.
REQ-011 rd_tag1 and rd_tag2, in, TAG_W each, operand lookup tags from reservation stations.
REQ-012 rd_ready1 and rd_ready2, out, 1 each, the looked-up entry holds a valid result.
REQ-013 rd_data1 and rd_data2, out, DATA_W each, the looked-up result.
REQ-014 commit_valid, out, 1, one-cycle pulse per retired entry.
REQ-015 commit_dest, out, REG_W, destination register of the retired entry.
REQ-016 commit_data, out, DATA_W, value of the retired entry.
REQ-017 count, out, TAG_W+1, occupied entries, 0..DEPTH.

Function
REQ-018 The buffer SHALL be circular with head (oldest) and tail (next free) pointers wrapping modulo DEPTH.
REQ-019 Each entry SHALL hold busy, ready, dest and data fields.
REQ-020 Allocation SHALL happen on a rising edge when alloc_valid and alloc_ready are both high: entry[tail] busy=1, ready=0, dest=alloc_dest; tail advances.
REQ-021 When full (count==DEPTH), alloc_ready SHALL be 0 and alloc_valid SHALL be ignored, even if a commit occurs in the same cycle.
REQ-022 On a rising edge with cdb_valid high, if entry[cdb_tag] is busy and not ready, the entry SHALL store cdb_data and set ready=1.
REQ-023 CDB writes to a non-busy or already-ready entry SHALL be ignored.
REQ-024 Commit SHALL be strictly in order: on each rising edge where entry[head] is busy and ready, the ROB registers commit_valid=1, commit_dest and commit_data, clears busy/ready, and advances head.
REQ-025 commit_valid SHALL be 0 on every edge without a retirement, and at most one entry SHALL retire per cycle.
REQ-026 An entry made ready by the CDB at edge N SHALL commit no earlier than edge N+1.
REQ-027 commit_valid SHALL therefore be observed high starting the cycle after edge N+1.
REQ-028 Younger ready entries SHALL wait behind a non-ready head.
REQ-029 count SHALL be updated as count + alloc - commit in the same edge; simultaneous alloc and commit leaves count unchanged.
REQ-030 rd_readyX/rd_dataX SHALL be combinational.
REQ-031 If cdb_valid is high, cdb_tag==rd_tagX and that entry is busy, rd_readyX SHALL be 1 and rd_dataX SHALL equal cdb_data (bypass).
REQ-032 Otherwise rd_readyX SHALL equal busy&ready of entry[rd_tagX], and rd_dataX SHALL equal its data.
REQ-033 rd_dataX SHALL be 0 when rd_readyX is 0.
REQ-034 alloc_tag and alloc_ready SHALL be combinational from tail and count.

Reset
REQ-035 When reset is low at a rising edge, the ROB SHALL clear head, tail and count to 0, clear all busy/ready bits, clear entry data/dest to 0, and set commit_valid, commit_dest and commit_data to 0.
REQ-036 Reset SHALL take priority over simultaneous alloc/CDB/commit activity.
REQ-037 Reset SHALL discard in-flight entries.
REQ-038 After reset, alloc_ready SHALL be 1 and alloc_tag SHALL be 0.

Structure
REQ-039 DATA_W, TAG_W, REG_W, DEPTH and the entry record type SHALL live in a shared package used by reservation stations and the adder unit.
REQ-040 One sub-module, rob_entry (single entry storage with alloc/write/clear controls), SHALL be replicated DEPTH times; pointer, count and commit logic SHALL stay in reorder_buffer.

Verification
REQ-041 Test: reset low one edge, then high -> count=0, alloc_ready=1, alloc_tag=0, commit_valid=0.
REQ-042 Test: alloc dest=3 (tag 0); CDB tag0 data=16'h00AA -> commit_valid pulses once with dest=3, data=16'h00AA, one cycle after the CDB edge; count returns to 0.
REQ-043 Test: alloc tags 0,1; CDB tag1=16'h1111 first, then tag0=16'h2222 -> commits in order: tag0 (16'h2222), then tag1 (16'h1111) on consecutive cycles.
REQ-044 Test: allocate 4 entries -> alloc_ready=0, count=4; a 5th alloc_valid is ignored; after head commits, alloc_tag=0 (wrap) and allocation succeeds.
REQ-045 Test: rd_tag1=2 while cdb_valid with tag2 and 16'h0F0F -> rd_ready1=1, rd_data1=16'h0F0F in the same cycle; CDB to a free tag leaves state unchanged.
REQ-046 Test: reset asserted with 3 busy entries -> all cleared, and no commit_valid follows.
